multicycle_controller: RTL and testbench

Moore-style control FSM that sequences the multicycle RV32I datapath (PC, IR, OldPC, register file, ALU, ALUOut, Data register, shared instruction/data memory) one instruction at a time. It drives every datapath select and write enable, including `ImmSrc` for the immediate sign-extension unit. It also reports instruction retirement and illegal encodings. Supported subset: lw, sw, R-type (add/sub/slt/xor/or/and), I-type ALU (addi/slti/xori/ori/andi), beq/bne/blt/bge, jal, jalr, lui.

---
 rtl/multicycle_controller.sv | 273 +++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a multicycle RV32I datapath.
// It sequences one instruction at a time through the datapath, which has a
// PC, IR, OldPC, register file, ALU, ALUOut, Data register and a shared
// instruction/data memory.
//
// Supported instructions: lw, sw, R-type ALU, I-type ALU, beq/bne/blt/bge,
// jal, jalr and lui.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset (state -> FETCH)
//   op         : instruction[6:0] from IR
//   funct3     : instruction[14:12]
//   funct7b5   : instruction[30]
//   zero, neg  : ALU flags, consumed combinationally in BRANCH
//   PCWrite, IRWrite, MemWrite, RegWrite : datapath write enables
//   AdrSrc     : memory address select   (0 PC, 1 Result)
//   ALUSrcA    : ALU A select            (00 PC, 01 OldPC, 10 RD1)
//   ALUSrcB    : ALU B select            (00 RD2, 01 ImmExt, 10 const 4)
//   ResultSrc  : result select           (00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt)
//   ALUControl : 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//   ImmSrc     : 000 I, 001 S, 010 B, 011 J, 100 U (decoded from op only)
//   instr_done : one-cycle pulse in an instruction's final state
//   illegal_op : one-cycle pulse in DECODE for an unsupported encoding
// -----------------------------------------------------------------------------
module multicycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       neg,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       instr_done,
   output logic       illegal_op
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic   decode_ok;
   logic   alu_f3_ok;
   logic   br_f3_ok;
   logic   br_taken;
   logic [2:0] exec_alu;

   // Encoding legality, evaluated against the IR fields held during DECODE.
   always_comb begin
      alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                  (funct3 == 3'b110) || (funct3 == 3'b111);
      br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
      case (op)
         OP_LW, OP_SW, OP_JAL, OP_JALR, OP_LUI: decode_ok = 1'b1;
         OP_R, OP_I:                            decode_ok = alu_f3_ok;
         OP_BR:                                 decode_ok = br_f3_ok;
         default:                               decode_ok = 1'b0;
      endcase
   end

   // ALU operation for EXECR/EXECI. funct7b5 selects sub only for
   // register-register operations; the I-type immediate overlaps that bit.
   always_comb begin
      case (funct3)
         3'b000:  exec_alu = (state_reg == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  exec_alu = ALU_SLT;
         3'b100:  exec_alu = ALU_XOR;
         3'b110:  exec_alu = ALU_OR;
         3'b111:  exec_alu = ALU_AND;
         default: exec_alu = ALU_ADD;
      endcase
   end

   // Branch condition from the subtract flags of the current BRANCH cycle.
   always_comb begin
      case (funct3)
         3'b000:  br_taken = zero;
         3'b001:  br_taken = ~zero;
         3'b100:  br_taken = neg;
         3'b101:  br_taken = ~neg;
         default: br_taken = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = S_FETCH;
      case (state_reg)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            if (!decode_ok) begin
               state_next = S_FETCH;
            end else begin
               case (op)
                  OP_LW, OP_SW: state_next = S_MEMADR;
                  OP_R:         state_next = S_EXECR;
                  OP_I:         state_next = S_EXECI;
                  OP_BR:        state_next = S_BRANCH;
                  OP_JAL:       state_next = S_JAL;
                  OP_JALR:      state_next = S_JALR;
                  OP_LUI:       state_next = S_LUI;
                  default:      state_next = S_FETCH;
               endcase
            end
         end
         S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next = S_MEMWB;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: state_next = S_FETCH;
         S_EXECR:    state_next = S_ALUWB;
         S_EXECI:    state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BRANCH:   state_next = S_FETCH;
         // jalr computes rs1+imm into ALUOut, then reuses JAL to load the PC
         // and ALUWB to write the link address.
         S_JALR:     state_next = S_JAL;
         S_JAL:      state_next = S_ALUWB;
         S_LUI:      state_next = S_FETCH;
         default:    state_next = S_FETCH;
      endcase
   end

   // Output logic
   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = ALU_ADD;
      instr_done = 1'b0;
      illegal_op = 1'b0;

      case (op)
         OP_SW:   ImmSrc = 3'b001;
         OP_BR:   ImmSrc = 3'b010;
         OP_JAL:  ImmSrc = 3'b011;
         OP_LUI:  ImmSrc = 3'b100;
         default: ImmSrc = 3'b000;
      endcase

      case (state_reg)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
         end
         S_DECODE: begin
            // OldPC + ImmExt -> ALUOut: branch/jal target ready in advance.
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b01;
            illegal_op = ~decode_ok;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            MemWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = exec_alu;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = exec_alu;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            PCWrite    = br_taken;
            instr_done = 1'b1;
         end
         S_JALR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_JAL: begin
            // PC <- ALUOut (target) while ALU forms OldPC+4 for the link.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         S_LUI: begin
            ResultSrc  = 2'b11;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
            PCWrite = 1'b0;
         end
      endcase

      // While reset is held, no write may occur and selects show FETCH values.
      if (rst) begin
         PCWrite    = 1'b0;
         IRWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
         AdrSrc     = 1'b0;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b10;
         ResultSrc  = 2'b10;
         ALUControl = ALU_ADD;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. For each instruction the model
// builds the list of per-cycle control words the instruction must produce.
// A compare process checks the DUT against that list on every falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   typedef struct packed {
      logic       pcw;
      logic       irw;
      logic       mw;
      logic       rw;
      logic       adr;
      logic [1:0] asa;
      logic [1:0] asb;
      logic [1:0] rs;
      logic [2:0] alu;
      logic [2:0] imm;
      logic       done;
      logic       ill;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op_i;
   logic [2:0] f3_i;
   logic       f7_i;
   logic       zero_i;
   logic       neg_i;

   logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instr_done, illegal_op;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0] ALUControl, ImmSrc;

   ctl_t  dut_v;
   ctl_t  exp_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   string cur_name = "reset";

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op_i), .funct3(f3_i), .funct7b5(f7_i),
      .zero(zero_i), .neg(neg_i),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign dut_v = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ALUControl, ImmSrc, instr_done, illegal_op};

   // ---------------- model ----------------
   function automatic logic [2:0] imm_for(input logic [6:0] o);
      case (o)
         7'b0100011: return 3'b001;
         7'b1100011: return 3'b010;
         7'b1101111: return 3'b011;
         7'b0110111: return 3'b100;
         default:    return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] alu_for(input logic is_r, input logic [2:0] f,
                                          input logic f7);
      case (f)
         3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b100:  return 3'b100;
         3'b110:  return 3'b011;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic legal(input logic [6:0] o, input logic [2:0] f);
      case (o)
         7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111: return 1'b1;
         7'b0110011, 7'b0010011: return f inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
         7'b1100011: return f inside {3'b000, 3'b001, 3'b100, 3'b101};
         default: return 1'b0;
      endcase
   endfunction

   function automatic ctl_t rst_row(input logic [2:0] imm);
      ctl_t r = '0;
      r.asb = 2'b10; r.rs = 2'b10; r.imm = imm;
      return r;
   endfunction

   // Push the control words one instruction must produce, cycle by cycle.
   task automatic build(input logic [6:0] o, input logic [2:0] f, input logic f7,
                        input logic z, input logic n);
      ctl_t base, r;
      logic taken;
      base = '0; base.imm = imm_for(o);
      // FETCH
      r = base; r.irw = 1; r.pcw = 1; r.asb = 2'b10; r.rs = 2'b10; exp_q.push_back(r);
      // DECODE
      r = base; r.asa = 2'b01; r.asb = 2'b01; r.ill = ~legal(o, f); exp_q.push_back(r);
      if (legal(o, f)) begin
         case (o)
            7'b0000011, 7'b0100011: begin
               r = base; r.asa = 2'b10; r.asb = 2'b01; exp_q.push_back(r);
               if (o == 7'b0000011) begin
                  r = base; r.adr = 1; exp_q.push_back(r);
                  r = base; r.rs = 2'b01; r.rw = 1; r.done = 1; exp_q.push_back(r);
               end else begin
                  r = base; r.adr = 1; r.mw = 1; r.done = 1; exp_q.push_back(r);
               end
            end
            7'b0110011, 7'b0010011: begin
               r = base; r.asa = 2'b10; r.asb = (o == 7'b0010011) ? 2'b01 : 2'b00;
               r.alu = alu_for(o == 7'b0110011, f, f7); exp_q.push_back(r);
               r = base; r.rw = 1; r.done = 1; exp_q.push_back(r);
            end
            7'b1100011: begin
               case (f)
                  3'b000:  taken = z;
                  3'b001:  taken = !z;
                  3'b100:  taken = n;
                  default: taken = !n;
               endcase
               r = base; r.asa = 2'b10; r.alu = 3'b001; r.pcw = taken; r.done = 1;
               exp_q.push_back(r);
            end
            7'b1100111, 7'b1101111: begin
               if (o == 7'b1100111) begin
                  r = base; r.asa = 2'b10; r.asb = 2'b01; exp_q.push_back(r);
               end
               r = base; r.asa = 2'b01; r.asb = 2'b10; r.pcw = 1; exp_q.push_back(r);
               r = base; r.rw = 1; r.done = 1; exp_q.push_back(r);
            end
            default: begin // lui
               r = base; r.rs = 2'b11; r.rw = 1; r.done = 1; exp_q.push_back(r);
            end
         endcase
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         ctl_t e;
         e = exp_q.pop_front();
         checks++;
         if (dut_v !== e) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%05h expected=%05h", cur_name, cyc, dut_v, e);
         end
         cyc++;
      end
   end

   task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", nm, got, want);
      end
   endtask

   // Load inputs and the expected sequence; pin the model's length.
   task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic f7,
                        input logic z, input logic n, input string nm, input int len);
      op_i = o; f3_i = f; f7_i = f7; zero_i = z; neg_i = n;
      cur_name = nm; cyc = 0;
      build(o, f, f7, z, n);
      check_eq({nm, "_len"}, exp_q.size(), len);
   endtask

   task automatic drain();
      int n;
      n = exp_q.size();
      repeat (n) @(posedge clk);
      #1;
      $display("txn %s cycles=%0d", cur_name, n);
   endtask

   initial begin
      rst = 1'b1; op_i = '0; f3_i = '0; f7_i = 1'b0; zero_i = 1'b0; neg_i = 1'b0;
      // Reset held across 3 edges: no enables, FETCH selects.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("reset_outputs", dut_v, rst_row(3'b000));
      end
      @(posedge clk); #1 rst = 1'b0;

      // lw: 5 cycles, pin the write-back word.
      issue(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, "lw", 5);
      check_eq("lw_wb_row", exp_q[4], 19'b0001000000100000010);
      drain();
      issue(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, "sw", 4);
      drain();
      issue(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, "sub", 4);
      check_eq("sub_alu", exp_q[2].alu, 3'b001);
      drain();
      issue(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, "addi_f7", 4);
      check_eq("addi_alu", exp_q[2].alu, 3'b000);
      drain();
      issue(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, "and", 4);
      drain();
      issue(7'b0010011, 3'b100, 1'b0, 1'b0, 1'b0, "xori", 4);
      drain();
      issue(7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, "slti", 4);
      drain();
      issue(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, "or", 4);
      drain();
      issue(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, "beq_z1", 3);
      check_eq("beq_taken", exp_q[2].pcw, 1'b1);
      drain();
      issue(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, "beq_z0", 3);
      drain();
      issue(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, "bne_z0", 3);
      drain();
      issue(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, "blt_n1", 3);
      drain();
      issue(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, "bge_n1", 3);
      check_eq("bge_not_taken", exp_q[2].pcw, 1'b0);
      drain();
      issue(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, "jalr", 5);
      drain();
      issue(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, "jal", 4);
      drain();
      issue(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, "lui", 3);
      drain();
      issue(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, "illegal_op", 2);
      drain();
      issue(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, "illegal_rf3", 2);
      drain();
      issue(7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0, "illegal_bf3", 2);
      drain();

      // sw abandoned by reset during MEMADR: no MemWrite afterwards.
      issue(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, "sw_rst", 4);
      void'(exp_q.pop_back());
      @(posedge clk); @(posedge clk);
      @(negedge clk); #1 rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("sw_rst_hold", dut_v, rst_row(3'b001));
      end
      @(posedge clk); #1 rst = 1'b0;
      $display("txn sw_rst abandoned");
      issue(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, "lw_after_rst", 5);
      drain();

      check_eq("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
